// File: rtl/ir_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ir_pkg: state encodings and default timing shared by IR transmitter/receiver.
// Revision: 1.0
// ----------------------------------------------------------------------------
package ir_pkg;

  localparam int COMMAND_WIDTH               = 12;
  localparam int DEFAULT_UNIT_CYCLES         = 16200;
  localparam int DEFAULT_CARRIER_HALF_PERIOD = 337;
  localparam int DEFAULT_START_UNITS         = 4;
  localparam int DEFAULT_FRAME_UNITS         = 75;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SPACE = 3'd2,
    MARK  = 3'd3,
    GAP   = 3'd4
  } ir_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ir_carrier_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ir_carrier_gen: free-running carrier, restartable so each burst begins high.
// Revision: 1.0
// ----------------------------------------------------------------------------
module ir_carrier_gen
  import ir_pkg::*;
#(
  parameter int HALF_PERIOD = DEFAULT_CARRIER_HALF_PERIOD
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic carrier
);

  localparam int CNT_W = max_int($clog2(HALF_PERIOD), 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             phase_q, phase_d;

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (restart) begin
      count_d = '0;
      phase_d = 1'b1;
    end else if (count_q == CNT_W'(HALF_PERIOD - 1)) begin
      count_d = '0;
      phase_d = ~phase_q;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      phase_q <= 1'b0;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  // Phase for the upcoming cycle, so a registered consumer lines up with it.
  assign carrier = phase_d;

endmodule
`default_nettype wire

// File: rtl/ir_command_transmitter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ir_command_transmitter: sends the 12-bit move command as repeating SIRC frames.
// Revision: 1.0
// ----------------------------------------------------------------------------
module ir_command_transmitter
  import ir_pkg::*;
#(
  parameter int UNIT_CYCLES         = DEFAULT_UNIT_CYCLES,
  parameter int CARRIER_HALF_PERIOD = DEFAULT_CARRIER_HALF_PERIOD,
  parameter int START_UNITS         = DEFAULT_START_UNITS,
  parameter int FRAME_UNITS         = DEFAULT_FRAME_UNITS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     transmit,
  input  logic [COMMAND_WIDTH-1:0] command,
  output logic                     ir_out,
  output logic                     envelope,
  output logic                     busy,
  output logic                     frame_done,
  output logic [7:0]               frames_sent
);

  localparam int FRAME_CYCLES = FRAME_UNITS * UNIT_CYCLES;
  localparam int TMR_W        = max_int($clog2(UNIT_CYCLES), 1);
  localparam int UCNT_W       = $clog2(max_int(START_UNITS, 2) + 1);
  localparam int FRM_W        = $clog2(FRAME_CYCLES + 1);
  localparam logic [3:0] LAST_BIT = 4'(COMMAND_WIDTH - 1);

  ir_state_e                state_q, state_d;
  logic [COMMAND_WIDTH-1:0] cmd_q, cmd_d;
  logic [3:0]               bit_idx_q, bit_idx_d;
  logic [TMR_W-1:0]         unit_tmr_q, unit_tmr_d;
  logic [UCNT_W-1:0]        unit_cnt_q, unit_cnt_d;
  logic [FRM_W-1:0]         frame_cnt_q, frame_cnt_d;
  logic                     envelope_q, envelope_d;
  logic                     ir_out_q, ir_out_d;
  logic                     busy_q, busy_d;
  logic                     frame_done_q, frame_done_d;
  logic [7:0]               frames_sent_q, frames_sent_d;

  logic [UCNT_W-1:0] seg_units;
  logic              unit_tick;
  logic              seg_end;
  logic              frame_last;
  logic              start_frame;
  logic              restart;
  logic              carrier;

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    bit_idx_d     = bit_idx_q;
    unit_tmr_d    = unit_tmr_q;
    unit_cnt_d    = unit_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    frame_done_d  = 1'b0;
    frames_sent_d = frames_sent_q;
    start_frame   = 1'b0;

    case (state_q)
      START:   seg_units = UCNT_W'(START_UNITS);
      MARK:    seg_units = cmd_q[bit_idx_q] ? UCNT_W'(2) : UCNT_W'(1);
      default: seg_units = UCNT_W'(1);
    endcase

    unit_tick  = (unit_tmr_q == TMR_W'(UNIT_CYCLES - 1));
    seg_end    = unit_tick && (unit_cnt_q == seg_units - 1'b1);
    frame_last = (frame_cnt_q == FRM_W'(FRAME_CYCLES - 1));

    if (state_q == IDLE) begin
      start_frame = transmit;
    end else begin
      frame_cnt_d = frame_cnt_q + 1'b1;
      unit_tmr_d  = unit_tick ? '0 : unit_tmr_q + 1'b1;
      if (seg_end) begin
        unit_cnt_d = '0;
      end else if (unit_tick) begin
        unit_cnt_d = unit_cnt_q + 1'b1;
      end

      // The frame length is fixed, so its end overrides whatever segment is running.
      if (frame_last) begin
        frame_done_d  = 1'b1;
        frames_sent_d = frames_sent_q + 8'd1;
        state_d       = IDLE;
        start_frame   = transmit;
      end else if (seg_end) begin
        case (state_q)
          START: state_d = SPACE;
          SPACE: state_d = MARK;
          MARK: begin
            if (bit_idx_q == LAST_BIT) begin
              state_d = GAP;
            end else begin
              bit_idx_d = bit_idx_q + 4'd1;
              state_d   = SPACE;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end

    if (start_frame) begin
      state_d     = START;
      cmd_d       = command;
      bit_idx_d   = 4'd0;
      unit_tmr_d  = '0;
      unit_cnt_d  = '0;
      frame_cnt_d = '0;
    end

    restart    = start_frame || ((state_d == MARK) && (state_q != MARK));
    envelope_d = (state_d == START) || (state_d == MARK);
    busy_d     = (state_d != IDLE);
    ir_out_d   = envelope_d & carrier;
  end

  ir_carrier_gen #(
    .HALF_PERIOD(CARRIER_HALF_PERIOD)
  ) u_carrier (
    .clock   (clock),
    .reset   (reset),
    .restart (restart),
    .carrier (carrier)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      bit_idx_q     <= '0;
      unit_tmr_q    <= '0;
      unit_cnt_q    <= '0;
      frame_cnt_q   <= '0;
      envelope_q    <= 1'b0;
      ir_out_q      <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frames_sent_q <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      bit_idx_q     <= bit_idx_d;
      unit_tmr_q    <= unit_tmr_d;
      unit_cnt_q    <= unit_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      envelope_q    <= envelope_d;
      ir_out_q      <= ir_out_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frames_sent_q <= frames_sent_d;
    end
  end

  assign ir_out      = ir_out_q;
  assign envelope    = envelope_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frames_sent = frames_sent_q;

endmodule
`default_nettype wire

// File: tb/tb_ir_command_transmitter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ir_command_transmitter: frame timing, repeats, reset abort and count wrap.
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ir_command_transmitter;

  localparam int UC = 8;
  localparam int HP = 2;
  localparam int SU = 4;
  localparam int FU = 50;
  localparam int FC = FU * UC;

  typedef struct {
    logic [11:0] cmd;
    int          env_high;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        transmit = 1'b0;
  logic [11:0] command = 12'h000;
  logic        ir_out, envelope, busy, frame_done;
  logic [7:0]  frames_sent;

  logic        transmit_w = 1'b0;
  logic        ir_out_w, envelope_w, busy_w, frame_done_w;
  logic [7:0]  frames_sent_w;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  ir_command_transmitter #(
    .UNIT_CYCLES(UC), .CARRIER_HALF_PERIOD(HP), .START_UNITS(SU), .FRAME_UNITS(FU)
  ) dut (
    .clock(clock), .reset(reset), .transmit(transmit), .command(command),
    .ir_out(ir_out), .envelope(envelope), .busy(busy),
    .frame_done(frame_done), .frames_sent(frames_sent)
  );

  // Short frames so the 8-bit frame count can wrap in a reasonable run.
  ir_command_transmitter #(
    .UNIT_CYCLES(1), .CARRIER_HALF_PERIOD(1), .START_UNITS(4), .FRAME_UNITS(40)
  ) dut_wrap (
    .clock(clock), .reset(reset), .transmit(transmit_w), .command(12'h5A5),
    .ir_out(ir_out_w), .envelope(envelope_w), .busy(busy_w),
    .frame_done(frame_done_w), .frames_sent(frames_sent_w)
  );

  // Reference model: the whole frame waveform is precomputed from the command.
  bit       m_wave [FC];
  bit       m_carr [FC];
  bit       m_in = 1'b0;
  bit       m_fd = 1'b0;
  int       m_pos = 0;
  bit [7:0] m_fs = 8'd0;

  function automatic void build(input logic [11:0] c);
    int p;
    int len;
    for (int i = 0; i < FC; i++) begin
      m_wave[i] = 1'b0;
      m_carr[i] = 1'b0;
    end
    p = 0;
    for (int k = 0; k < SU * UC; k++) begin
      m_wave[p] = 1'b1;
      m_carr[p] = ((k / HP) % 2) == 0;
      p++;
    end
    for (int b = 0; b < 12; b++) begin
      p = p + UC;
      len = c[b] ? 2 * UC : UC;
      for (int k = 0; k < len; k++) begin
        m_wave[p] = 1'b1;
        m_carr[p] = ((k / HP) % 2) == 0;
        p++;
      end
    end
  endfunction

  function automatic void model_step(input logic rst, input logic tx, input logic [11:0] c);
    m_fd = 1'b0;
    if (rst) begin
      m_in  = 1'b0;
      m_fs  = 8'd0;
      m_pos = 0;
    end else if (!m_in) begin
      if (tx) begin
        m_in  = 1'b1;
        m_pos = 0;
        build(c);
      end
    end else begin
      m_pos++;
      if (m_pos == FC) begin
        m_fd = 1'b1;
        m_fs = m_fs + 8'd1;
        if (tx) begin
          m_pos = 0;
          build(c);
        end else begin
          m_in  = 1'b0;
          m_pos = 0;
        end
      end
    end
  endfunction

  function automatic logic [11:0] exp_vec();
    bit e;
    bit i;
    e = m_in ? m_wave[m_pos] : 1'b0;
    i = e && (m_in ? m_carr[m_pos] : 1'b0);
    return {i, e, m_in, m_fd, m_fs};
  endfunction

  function automatic void check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step(reset, transmit, command);
    @(negedge clock);
    check("cycle{ir,env,busy,fd,fs}", {20'd0, ir_out, envelope, busy, frame_done, frames_sent},
          {20'd0, exp_vec()});
  endtask

  // Runs until frame_done; a frame already showing envelope counts from this cycle.
  task automatic run_until_done(input int limit, input int chg_at, input logic [11:0] chg_cmd,
                                output int env_n, output int lat_n, output bit ok_n);
    int first;
    first = envelope ? 0 : -1;
    env_n = envelope ? 1 : 0;
    lat_n = -1;
    ok_n  = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      tick();
      if (c == chg_at) command = chg_cmd;
      if (frame_done) begin
        lat_n = c - first;
        ok_n  = 1'b1;
        break;
      end
      if (envelope) begin
        env_n++;
        if (first < 0) first = c;
      end
    end
  endtask

  task automatic frame(input string tag, input int exp_env, input int chg_at,
                       input logic [11:0] chg_cmd);
    int  env_n;
    int  lat_n;
    bit  ok_n;
    run_until_done(FC + 50, chg_at, chg_cmd, env_n, lat_n, ok_n);
    check({tag, "_done_seen"}, int'(ok_n), 1);
    if (ok_n) begin
      check({tag, "_env_cycles"}, env_n, exp_env);
      check({tag, "_latency"}, lat_n, FC);
    end
  endtask

  task automatic wait_wrap_done(output bit ok_n);
    ok_n = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (frame_done_w) begin
        ok_n = 1'b1;
        break;
      end
    end
  endtask

  vec_t       tbl [5];
  bit         ok;
  bit         done;
  int         hold;
  int         fd_count;
  logic [7:0] fs0;

  initial begin
    tbl[0] = '{cmd: 12'h010, env_high: 136};
    tbl[1] = '{cmd: 12'hFFF, env_high: 224};
    tbl[2] = '{cmd: 12'h000, env_high: 128};
    tbl[3] = '{cmd: 12'h0AB, env_high: 168};
    tbl[4] = '{cmd: 12'h555, env_high: 176};

    reset = 1'b1;
    repeat (3) tick();
    check("reset_state", {20'd0, ir_out, envelope, busy, frame_done, frames_sent}, 0);
    reset = 1'b0;
    repeat (2) tick();

    // Single-cycle transmit pulses; commands scrambled after the latch cycle.
    for (int i = 0; i < 5; i++) begin
      command  = tbl[i].cmd;
      transmit = 1'b1;
      tick();
      transmit = 1'b0;
      check("env_rise_after_pulse", int'(envelope), 1);
      frame("table", tbl[i].env_high, 1, 12'($urandom));
      check("busy_falls_with_done", int'(busy), 0);
      repeat (3) tick();
    end

    // Back-to-back frames while transmit is held.
    fs0      = frames_sent;
    command  = 12'hFFF;
    transmit = 1'b1;
    tick();
    frame("held1", 224, -1, 12'h000);
    check("no_idle_busy", int'(busy), 1);
    check("no_idle_env", int'(envelope), 1);
    transmit = 1'b0;
    frame("held2", 224, -1, 12'h000);
    check("held_frames_sent", int'(frames_sent), int'(fs0 + 8'd2));

    // Command change mid-frame only affects the next frame.
    repeat (3) tick();
    command  = 12'h010;
    transmit = 1'b1;
    tick();
    frame("chg_first", 136, 100, 12'h0AB);
    transmit = 1'b0;
    frame("chg_second", 168, -1, 12'h000);

    // Reset during bit 6 mark aborts the frame.
    repeat (3) tick();
    command  = 12'h010;
    transmit = 1'b1;
    tick();
    transmit = 1'b0;
    repeat (146) tick();
    check("in_bit6_mark", int'(envelope), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_outputs", {20'd0, ir_out, envelope, busy, frame_done, frames_sent}, 0);
    fd_count = 0;
    for (int c = 0; c < FC + 50; c++) begin
      tick();
      if (frame_done) fd_count++;
    end
    check("no_done_after_abort", fd_count, 0);
    command  = 12'h0AB;
    transmit = 1'b1;
    tick();
    transmit = 1'b0;
    frame("after_abort", 168, -1, 12'h000);
    check("after_abort_count", int'(frames_sent), 1);

    // Randomized transmit lengths and command churn against the model.
    for (int r = 0; r < 6; r++) begin
      hold     = int'($urandom_range(1, 900));
      command  = 12'($urandom);
      transmit = 1'b1;
      for (int c = 0; c < hold; c++) begin
        tick();
        command = 12'($urandom);
      end
      transmit = 1'b0;
      done = 1'b0;
      for (int c = 0; c < FC + 100; c++) begin
        tick();
        if (!busy) begin
          done = 1'b1;
          break;
        end
      end
      check("random_drain", int'(done), 1);
    end

    // frames_sent wraps from 255 to 0 on the short-frame instance.
    transmit_w = 1'b1;
    for (int n = 1; n <= 256; n++) begin
      wait_wrap_done(ok);
      if (!ok) begin
        check("wrap_done_seen", int'(ok), 1);
        break;
      end
      if (n == 1 || n >= 254) check("wrap_count", int'(frames_sent_w), n & 255);
      if (n == 255) begin
        transmit_w = 1'b0;
        check("wrap_restart_busy", int'(busy_w), 1);
      end
    end
    check("wrap_idle_after", int'(busy_w), 0);
    transmit_w = 1'b1;
    tick();
    transmit_w = 1'b0;
    check("wrap_new_frame", int'(busy_w), 1);
    wait_wrap_done(ok);
    check("wrap_new_done_seen", int'(ok), 1);
    check("wrap_new_count", int'(frames_sent_w), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
